// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO sequencer for MULT/MULTU/MTHI/MTLO (+DIV/DIVU).
// Radix-2 iterative multiply / restoring divide, WIDTH steps, then fix-up.
// Optional divide hardware: define HILO_DIV_EN.
// Ports: clk, rst_n (async low); start, op[2:0], src_a, src_b: request;
//   rd_req: MFHI/MFLO in EX; cancel: flush; hi, lo: HI/LO registers;
//   busy: not idle; stall: busy & (start | rd_req); done: commit pulse.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg_res;

  logic             ok_mul;
  logic             ok_mth;
  logic             ok_mtl;
  logic             sgn;
  logic             sa;
  logic             sb;
  logic             take;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   nx_hi;
  logic [WIDTH-1:0]   nx_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mres;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef HILO_DIV_EN
  logic             ok_div;
  logic             is_div;
  logic             neg_rem;
  logic             dz;
  logic [WIDTH:0]   dtry;

  assign ok_div = (op[2:1] == 2'b01);
`endif

  assign ok_mul = (op[2:1] == 2'b00);
  assign ok_mth = (op == 3'b100);
  assign ok_mtl = (op == 3'b101);

  // Even op codes (MULT/DIV) are the signed variants.
  assign sgn   = ~op[0];
  assign sa    = sgn & src_a[WIDTH-1];
  assign sb    = sgn & src_b[WIDTH-1];
  assign mag_a = sa ? -src_a : src_a;
  assign mag_b = sb ? -src_b : src_b;

  assign take  = (state == IDLE) & start & ~cancel;
  assign busy  = (state != IDLE);
  assign stall = busy & (start | rd_req);

  // acc_hi:acc_lo is the product register (multiply)
  // or remainder:quotient-shift register (divide).
  always_comb begin
    msum  = {1'b0, acc_hi} + ({1'b0, opb} & {(WIDTH+1){acc_lo[0]}});
    nx_hi = msum[WIDTH:1];
    nx_lo = {msum[0], acc_lo[WIDTH-1:1]};
`ifdef HILO_DIV_EN
    dtry  = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};
    if (is_div) begin
      if (!dtry[WIDTH]) begin
        nx_hi = dtry[WIDTH-1:0];
        nx_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nx_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        nx_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    prod   = {acc_hi, acc_lo};
    mres   = neg_res ? -prod : prod;
    fix_hi = mres[2*WIDTH-1:WIDTH];
    fix_lo = mres[WIDTH-1:0];
`ifdef HILO_DIV_EN
    // Zero divisor: quotient forced to all-ones; the remainder
    // path already reproduces the latched dividend.
    if (is_div) begin
      fix_lo = dz ? '1 : (neg_res ? -acc_lo : acc_lo);
      fix_hi = neg_rem ? -acc_hi : acc_hi;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      opb     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg_res <= 1'b0;
`ifdef HILO_DIV_EN
      is_div  <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            unique case (1'b1)
              ok_mth: hi <= src_a;
              ok_mtl: lo <= src_a;
              ok_mul: begin
                opb     <= mag_a;
                acc_hi  <= '0;
                acc_lo  <= mag_b;
                neg_res <= sa ^ sb;
                cnt     <= '0;
                state   <= RUN;
`ifdef HILO_DIV_EN
                is_div  <= 1'b0;
`endif
              end
`ifdef HILO_DIV_EN
              ok_div: begin
                opb     <= mag_b;
                acc_hi  <= '0;
                acc_lo  <= mag_a;
                neg_res <= sa ^ sb;
                neg_rem <= sa;
                dz      <= (src_b == '0);
                is_div  <= 1'b1;
                cnt     <= '0;
                state   <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            acc_hi <= nx_hi;
            acc_lo <= nx_lo;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH-1))
              state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed + random stimulus against a behavioural
// HI/LO model; outputs compared every cycle on the falling edge.
module tb_hilo_muldiv;

  localparam int W = 32;
`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         rd_req = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .rd_req(rd_req),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy),
    .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    logic [63:0] ua;
    logic [63:0] ub;
    if (o == 3'd0) begin
      x = {{32{a[31]}}, a};
      y = {{32{b[31]}}, b};
      return 64'(x * y);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Returns {hi, lo}.
  function automatic logic [63:0] div_ref(input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (o == 3'd3) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF)
      return {32'h0, 32'h80000000};
    sa = a;
    sb = b;
    q = 32'(sa / sb);
    r = 32'(sa % sb);
    return {r, q};
  endfunction

  // Behavioural model: cycles-left counter plus pending result.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] r_hi = '0;
  logic [31:0] r_lo = '0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [63:0] tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        if (cancel) m_cnt = 0;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_hi = r_hi; m_lo = r_lo; m_done = 1'b1;
          end
        end
      end else if (start && !cancel) begin
        case (op)
          3'd4: m_hi = src_a;
          3'd5: m_lo = src_a;
          3'd0, 3'd1: begin
            tmp = mul_ref(op, src_a, src_b);
            r_hi = tmp[63:32]; r_lo = tmp[31:0];
            m_cnt = W + 1;
          end
          3'd2, 3'd3: if (DIV_EN) begin
            tmp = div_ref(op, src_a, src_b);
            r_hi = tmp[63:32]; r_lo = tmp[31:0];
            m_cnt = W + 1;
          end
          default: ;
        endcase
      end
    end
  end

  bit chk_en = 1'b1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("busy", busy, m_cnt > 0);
      chk("done", done, m_done);
      chk("stall", stall, (m_cnt > 0) && (start || rd_req));
    end
  end

  task automatic drive(input bit s, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    start = s; op = o; src_a = a; src_b = b;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    drive(1'b1, o, a, b);
    drive(1'b0, o, a, b);
  endtask

  task automatic wait_idle(output int n, output int ns);
    n = 0;
    ns = 0;
    do begin
      @(negedge clk);
      if (busy) n++;
      if (stall) ns++;
    end while (busy && n < 200);
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy stuck after %0d cycles", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  int n;
  int ns;

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    issue(3'd4, 32'h12345678, 32'h0);
    @(negedge clk);
    chk("mthi", hi, 32'h12345678);
    chk("mthi_busy", busy, 1'b0);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n, ns);
    chk("multu_lat", n, 33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    chk("multu_done", done, 1'b1);
    @(negedge clk);
    chk("multu_done_end", done, 1'b0);

    @(posedge clk);
    #2;
    start = 1'b1; op = 3'd0; src_a = 32'hFFFFFFFD; src_b = 32'd7;
    rd_req = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_idle(n, ns);
    chk("mult_stall_cycles", ns, 33);
    chk("mult_stall_end", stall, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    rd_req = 1'b0;

`ifdef HILO_DIV_EN
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n, ns);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n, ns);
    chk("divu0_lat", n, 33);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd5);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n, ns);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    wait_idle(n, ns);
    chk("div_neg_b_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_b_hi", hi, 32'd1);
`else
    issue(3'd3, 32'd5, 32'd3);
    @(negedge clk);
    chk("nodiv_busy", busy, 1'b0);
    chk("nodiv_hi", hi, 32'hFFFFFFFF);
    chk("nodiv_lo", lo, 32'hFFFFFFEB);
`endif

    issue(3'd4, 32'h11111111, 32'h0);
    issue(3'd5, 32'h22222222, 32'h0);
    issue(3'd0, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #2 cancel = 1'b1;
    @(posedge clk);
    #2;
    cancel = 1'b0;
    start = 1'b1; op = 3'd5; src_a = 32'hA5;
    #1;
    chk("cancel_busy", busy, 1'b0);
    chk("cancel_hi", hi, 32'h11111111);
    chk("cancel_lo", lo, 32'h22222222);
    @(posedge clk);
    #2 start = 1'b0;
    @(negedge clk);
    chk("mtlo_after_cancel", lo, 32'hA5);

    @(posedge clk);
    #2;
    start = 1'b1; op = 3'd4; src_a = 32'hDEADBEEF; cancel = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_wins", hi, 32'h11111111);

    issue(3'd6, 32'h1, 32'h2);
    @(negedge clk);
    chk("invalid_busy", busy, 1'b0);
    chk("invalid_lo", lo, 32'hA5);

    issue(3'd1, 32'd2, 32'd3);
    repeat (2) @(posedge clk);
    #2;
    start = 1'b1; op = 3'd4; src_a = 32'h55;
    @(negedge clk);
    chk("busy_start_stall", stall, 1'b1);
    @(posedge clk);
    #2 start = 1'b0;
    wait_idle(n, ns);
    chk("busy_start_hi", hi, 32'h0);
    chk("busy_start_lo", lo, 32'd6);

    issue(3'd0, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_lo", lo, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      start  = ($urandom_range(0, 3) == 0);
      op     = 3'($urandom_range(0, 7));
      src_a  = pick();
      src_b  = pick();
      rd_req = $urandom_range(0, 1);
      cancel = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(posedge clk);
    #2;
    start = 1'b0; rd_req = 1'b0; cancel = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle sequencer for the HI/LO register pair used by MULT/MULTU/MTHI/MTLO (and, optionally, DIV/DIVU). It sits beside the ALU in the execute stage and takes operation requests decoded by the control unit. It runs a radix-2 iterative multiply (or restoring divide) over 32 cycles and then commits the 64-bit result to HI/LO. It raises a stall to the pipeline whenever a new HI/LO request or an MFHI/MFLO read collides with an operation in progress.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are `WIDTH` bits each, and the iteration count equals `WIDTH`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request strobe. It is accepted only in IDLE with `cancel`=0.
- `op`  in  3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are ignored.
- `src_a`  in  WIDTH: rs operand (multiplicand/dividend, or the MTHI/MTLO data).
- `src_b`  in  WIDTH: rt operand (multiplier/divisor).
- `rd_req`  in  1: MFHI/MFLO in execute this cycle.
- `cancel`  in  1: flush from exception/ERET. Aborts any operation in progress.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.
- `busy`  out  1: high whenever the state is not IDLE.
- `stall`  out  1: combinational, equal to `busy & (start | rd_req)`.
- `done`  out  1: one-cycle pulse on the cycle after HI/LO commit from MULT/DIV.

## Operation
- Reset values: the state machine is IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, and the counter is 0.
- IDLE, MTHI/MTLO: `hi` (or `lo`) is loaded with `src_a` at the next edge. The state machine does not leave IDLE and `done` is not pulsed.
- IDLE, MULT/MULTU/DIV/DIVU accepted: the block latches the operand magnitudes and sign flags (signed ops only), clears the counter, and goes to RUN.
- RUN: performs one shift-add or shift-subtract step per cycle. The counter increments every cycle; when the counter reaches `WIDTH`-1 the block goes to FIX.
- FIX: applies sign correction and then writes `hi`/`lo`, then returns to IDLE.
  - Multiply: the product is negated in 2*WIDTH bits when the operand signs differ. `hi` receives product[63:32] and `lo` receives product[31:0].
  - Divide: `lo` receives the quotient, negated if the operand signs differ. `hi` receives the remainder, which takes the sign of the dividend.
- Divide by zero (DIVU or DIV): `lo`=all-ones, `hi`=`src_a` as latched. The block takes no early exit and still uses the full latency.
- Signed edge case: DIV of 0x80000000 by 0xFFFFFFFF gives `lo`=0x80000000 and `hi`=0 (wraps, no trap).
- `start` while busy: the request is ignored and `stall`=1. The pipeline must hold and re-present the request.
- `cancel` in RUN or FIX: the state goes to IDLE at the next edge. `hi`/`lo` are unchanged and `done` is not pulsed.
- `cancel` together with `start` in IDLE: `cancel` wins and nothing is accepted, including MTHI/MTLO.
- Invalid `op` (110/111) with `start`: ignored, no state change.

## Timing
- MTHI/MTLO: 1-cycle latency. The new value is visible on `hi`/`lo` immediately after the accepting edge E0.
- MULT/DIV timeline:
  - Accepting edge E0: `busy` rises.
  - Edges E1 through E32: RUN steps.
  - Edge E33 (FIX→IDLE): `hi`/`lo` are written and `busy` falls.
  - `done`=1 for the single cycle between E33 and E34.
- `busy` is therefore high for exactly `WIDTH`+1 cycles.
- A new `start` is accepted in the same cycle that `done` is high.
- `rd_req` in that same cycle reads the committed `hi`/`lo` with no stall.
- Asserting `rst_n` low mid-operation clears everything immediately, without waiting for a clock edge.

## Configuration
- `HILO_DIV_EN` defined: DIV and DIVU are implemented as described above.
- `HILO_DIV_EN` undefined:
  - op 010/011 are treated like invalid codes: ignored, no busy, HI/LO unchanged.
  - The divide datapath (subtractor and remainder register path) is not synthesized.

## Test plan
- Reset, then MTHI with `src_a`=0x12345678 → `hi`=0x12345678 after one edge, `busy` stays 0.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles, `hi`=0xFFFFFFFE, `lo`=0x00000001, and `done` pulses once.
- MULT with 0xFFFFFFFD (−3) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. `rd_req` held high mid-run gives `stall`=1 until `busy` falls.
- DIV of −7 by 2 (`HILO_DIV_EN` defined) → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU of 5 by 0 → `lo`=0xFFFFFFFF, `hi`=5.
- Without the macro, DIVU → `busy` never rises and HI/LO keep their previous values.
- MULT started, `cancel` asserted at cycle 10 → IDLE at the next edge, HI/LO keep prior values, no `done`. A following `start` with MTLO (0xA5) is accepted next cycle and gives `lo`=0xA5.
